tree_adder_arb: RTL and testbench
=================================

# tree_adder_arb

Round-robin scheduler that shares a single combinational `tree_adder` (SIZE lanes × WIDTH bits) between NREQ requesters. Each requester streams a burst of SIZE-element vectors. The block locks the adder to that requester for the whole burst and accumulates the per-beat tree sums. It returns one WIDTH-bit total per burst, tagged with the requester index, over a valid/ready result port. It sits between the reduction clients and the `tree_adder` datapath.

## Interface
- `WIDTH`, 8, element and result width in bits
- `SIZE`, 4, lanes per beat fed to `tree_adder`
- `NREQ`, 4, number of requesters (≥2)
- `IDW`, `$clog2(NREQ)`, width of the requester index (derived, not overridden)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  NREQ  per-requester beat valid
- `req_ready`  out  NREQ  per-requester beat accept (one-hot or zero)
- `req_data`  in  NREQ*SIZE*WIDTH  requester r's beat is slice r, packed like `tree_adder` `data_in`
- `req_last`  in  NREQ  marks final beat of burst
- `res_valid`  out  1  burst total available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  WIDTH  burst total
- `res_id`  out  IDW  requester that owned the burst

## Operation
- FSM states are IDLE, BURST and RESP.
- **IDLE:**
  - If any `req_valid` is high, `rr_arbiter` picks the first valid index at or after `rr_ptr`, wrapping modulo NREQ.
  - The winner is registered into `grant`, `acc` is cleared to 0, and the FSM goes to BURST.
  - `req_ready` is all zero in IDLE.
- **BURST:**
  - `req_ready[grant]` = 1; all other `req_ready` bits = 0.
  - On `req_valid[grant] & req_ready[grant]`, `sum` = `tree_adder`(slice `grant`) mod 2^WIDTH, and `acc` ← (`acc` + `sum`) mod 2^WIDTH.
  - If `req_last[grant]` is set on that beat, the FSM goes to RESP.
  - Valid from non-granted requesters is ignored; those requesters must hold their data.
- **RESP:**
  - `res_valid` = 1, `res_data` = `acc`, `res_id` = `grant`.
  - On `res_ready`, `rr_ptr` ← (`grant`+1) mod NREQ and the FSM goes to IDLE.
- Requester rules: a requester must keep `req_valid` and `req_data` stable until accepted. It may drop `req_valid` mid-burst (a stall); the grant is held until `last`.
- A one-beat burst (`last` on the first beat) is legal.
- All arithmetic wraps modulo 2^WIDTH unless `TREE_ADDER_ARB_SAT_EN` is defined.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, state=IDLE, `rr_ptr`=0, `acc`=0, `grant`=0.
- Asserting reset mid-burst or in RESP discards the burst; no result is emitted.
- Arbitration: `req_valid` sampled in IDLE at edge t gives `req_ready` at cycle t+1.
- Throughput in BURST: one beat per cycle.
- Result latency: the last beat accepted at edge t gives `res_valid` at cycle t+1.
- `res_valid` stays high, with `res_data` and `res_id` stable, until `res_ready`. Backpressure is unlimited.
- Minimum burst cost: beats + 2 cycles (IDLE arbitration + RESP with `res_ready` held high).
- Simultaneous requests: strict round-robin.
  - After burst from r, priority order is r+1, r+2, …, wrapping.
  - A lone requester may win consecutive bursts.
- The `tree_adder` output is consumed combinationally in the same cycle as the beat. `req_data` is not registered before the adder.

## Configuration
- `TREE_ADDER_ARB_SAT_EN` defined:
  - Accumulation is computed in WIDTH+1 bits.
  - If the carry is set or `acc` is already saturated, `acc` becomes 2^WIDTH−1 and stays there until the burst ends.
  - Per-beat `sum` still wraps inside `tree_adder`.
- `TREE_ADDER_ARB_SAT_EN` undefined: `acc` wraps modulo 2^WIDTH. No extra logic is generated.

## Structure
- Package `tree_adder_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, BURST, RESP)
  - the localparam helpers for IDW
- Sub-module `rr_arbiter`: NREQ-wide request vector plus pointer in, one-hot grant plus `any` out, purely combinational.
- `tree_adder` is instantiated once (WIDTH, SIZE), fed by an NREQ:1 mux on `grant`.

## Test plan
- Single requester 0, one beat {01,02,03,04} with `last`, `res_ready`=1 → `res_valid` one cycle after accept, `res_data`=0A, `res_id`=0.
- Requester 2 sends 3 beats, each {01,01,01,01}, `last` on the third → `res_data`=0C, `res_id`=2. `req_ready[2]` is high for 3 beats; other `req_ready` bits stay 0.
- Requesters 0, 1 and 3 all valid from reset, one-beat bursts → results in order id 0, 1, 3, then 0 again if 0 re-requests.
- Overflow with macro undefined: 2 beats of {FF,FF,FF,FF} → `res_data`=F8. With `TREE_ADDER_ARB_SAT_EN` defined, the same stimulus gives `res_data`=FF.
- Backpressure: `res_ready`=0 for 5 cycles in RESP → `res_valid`, `res_data` and `res_id` stay stable, no new `req_ready`, and exactly one result on release.
- `rst_n` pulsed low mid-burst after beat 1 of 3 → all outputs are 0 immediately, the burst is not reported, and a next burst from requester 0 gives the correct sum.

Source files
------------

// File: rtl/tree_adder_arb_pkg.sv
// tree_adder_arb_pkg: shared types and sizing helpers for the tree_adder_arb
// scheduler (FSM state enum, requester-index width helper).
package tree_adder_arb_pkg;

   // Scheduler states: arbitrate, stream a locked burst, present the total.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // Width of a requester index; never below one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_SIZE  = 4;
   localparam int unsigned DEF_NREQ  = 4;

endpackage

// File: rtl/tree_adder.sv
// tree_adder: combinational reduction of SIZE lanes of WIDTH bits, result
// wraps modulo 2^WIDTH. Lane i lives at data_in[i*WIDTH +: WIDTH].
// Ports: data_in (SIZE*WIDTH packed lanes), sum_c (WIDTH-bit wrapped sum).
module tree_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned SIZE  = 4
) (
   input  logic [SIZE*WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]      sum_c
);

   // Linear description; synthesis rebalances it into an adder tree.
   always_comb begin
      sum_c = '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         sum_c = sum_c + data_in[i*WIDTH +: WIDTH];
      end
   end

endmodule

// File: rtl/tree_adder_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first asserted request
// at or after ptr, wrapping modulo NREQ.
// Ports: req (request vector), ptr (start index), gnt_c (one-hot grant),
// any_c (at least one request present).
module rr_arbiter
   import tree_adder_arb_pkg::*;
#(
   parameter  int unsigned NREQ = DEF_NREQ,
   localparam int unsigned IDW  = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt_c,
   output logic            any_c
);

   int unsigned      pos;
   logic [IDW-1:0]   idx;

   // Walk NREQ positions starting at ptr; first hit wins.
   always_comb begin
      gnt_c = '0;
      any_c = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= NREQ) pos = pos - NREQ;
         idx = IDW'(pos);
         if (!any_c && req[idx]) begin
            gnt_c[idx] = 1'b1;
            any_c      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tree_adder_arb.sv
// tree_adder_arb: round-robin scheduler sharing one tree_adder among NREQ
// requesters. A granted requester owns the adder for a whole burst; the
// per-beat sums are accumulated and one total per burst is returned, tagged
// with the owner index.
// Ports: clk, rst_n (async active-low); req_valid/req_ready/req_data/req_last
// per-requester beat stream; res_valid/res_ready/res_data/res_id result port.
// Option: define TREE_ADDER_ARB_SAT_EN to saturate the burst accumulator at
// 2^WIDTH-1 instead of wrapping.
module tree_adder_arb
   import tree_adder_arb_pkg::*;
#(
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned SIZE  = DEF_SIZE,
   parameter  int unsigned NREQ  = DEF_NREQ,
   localparam int unsigned IDW   = idx_w(NREQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*SIZE*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]            req_last,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [WIDTH-1:0]           res_data,
   output logic [IDW-1:0]             res_id
);

   localparam int unsigned BEAT_W = SIZE * WIDTH;

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [NREQ-1:0]  req_ready_q, req_ready_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [IDW-1:0]   res_id_q, res_id_d;

   logic [NREQ-1:0]  win_oh;
   logic             win_any;
   logic [IDW-1:0]   win_idx;
   logic [BEAT_W-1:0] beat_data;
   logic [WIDTH-1:0] beat_sum;
   logic [WIDTH-1:0] acc_nxt;
   logic             beat_fire;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .gnt_c (win_oh),
      .any_c (win_any)
   );

   // One-hot winner to index.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_oh[i]) win_idx = IDW'(i);
      end
   end

   // NREQ:1 mux feeding the shared adder; data goes straight in, unregistered.
   always_comb begin
      beat_data = '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
         if (grant_q == IDW'(r)) beat_data = req_data[r*BEAT_W +: BEAT_W];
      end
   end

   tree_adder #(.WIDTH(WIDTH), .SIZE(SIZE)) u_tree (
      .data_in (beat_data),
      .sum_c   (beat_sum)
   );

   // req_ready_q only ever holds the granted bit, so this is the owner's handshake.
   assign beat_fire = req_valid[grant_q] & req_ready_q[grant_q];

`ifdef TREE_ADDER_ARB_SAT_EN
   logic [WIDTH:0] acc_wide;

   // Carry out of the widened add (or an already-pinned acc) clamps to all-ones.
   always_comb begin
      acc_wide = {1'b0, acc_q} + {1'b0, beat_sum};
      acc_nxt  = (acc_wide[WIDTH] || (&acc_q)) ? '1 : acc_wide[WIDTH-1:0];
   end
`else
   assign acc_nxt = acc_q + beat_sum;
`endif

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      acc_d       = acc_q;
      req_ready_d = req_ready_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               grant_d     = win_idx;
               acc_d       = '0;
               req_ready_d = win_oh;
               state_d     = BURST;
            end
         end
         BURST: begin
            if (beat_fire) begin
               acc_d = acc_nxt;
               if (req_last[grant_q]) begin
                  req_ready_d = '0;
                  res_valid_d = 1'b1;
                  res_data_d  = acc_nxt;
                  res_id_d    = grant_q;
                  state_d     = RESP;
               end
            end
         end
         RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               rr_ptr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
               state_d     = IDLE;
            end
         end
         default: begin
            req_ready_d = '0;
            res_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         acc_q       <= '0;
         req_ready_q <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         acc_q       <= acc_d;
         req_ready_q <= req_ready_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
      end
   end

   assign req_ready = req_ready_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule

// File: tb/tb_tree_adder_arb.sv
// tb_tree_adder_arb: directed bench for tree_adder_arb. Per-requester beat
// queues drive the request ports; expected burst totals come from a plain
// arithmetic model; a monitor checks handshakes, latency and stability.
module tb_tree_adder_arb;

   localparam int N   = 4;
   localparam int S   = 4;
   localparam int W   = 8;
   localparam int BW  = S * W;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*BW-1:0]   req_data;
   logic [N-1:0]      req_last;
   logic              res_valid;
   logic              res_ready;
   logic [W-1:0]      res_data;
   logic [IDW-1:0]    res_id;

   always #5 clk = ~clk;

   tree_adder_arb #(.WIDTH(W), .SIZE(S), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_last  (req_last),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id)
   );

   typedef struct packed {
      logic          v;
      logic          l;
      logic [BW-1:0] d;
   } beat_t;

   beat_t        bq[N][$];
   logic [W-1:0] exp_q[N][$];
   int           exp_id_q[$];
   int           got_id_q[$];
   logic [W-1:0] got_data_q[$];
   int checks = 0, errors = 0, nres = 0, cyc = 0, last_fire_cyc = -10;
   int fire_cnt[N];
   int rdy_cnt[N];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Burst total from the arithmetic rules: lane sums wrap, accumulation wraps or clamps.
   function automatic logic [W-1:0] model_total(input logic [BW-1:0] beats[4], input int n);
      int acc = 0;
      for (int b = 0; b < n; b++) begin
         int s = 0;
         for (int l = 0; l < S; l++) s += int'(beats[b][l*W +: W]);
         s = s % 256;
`ifdef TREE_ADDER_ARB_SAT_EN
         acc = acc + s;
         if (acc > 255) acc = 255;
`else
         acc = (acc + s) % 256;
`endif
      end
      return W'(acc);
   endfunction

   task automatic add_burst(input int r, input logic [BW-1:0] beats[4], input int n, input int gap_after);
      for (int i = 0; i < n; i++) begin
         bq[r].push_back('{v: 1'b1, l: (i == n - 1), d: beats[i]});
         if (i == gap_after) bq[r].push_back('{v: 1'b0, l: 1'b0, d: '0});
      end
      exp_q[r].push_back(model_total(beats, n));
   endtask

   task automatic flush_all();
      for (int r = 0; r < N; r++) begin
         bq[r].delete();
         exp_q[r].delete();
      end
      exp_id_q.delete();
      req_valid = '0;
      req_last  = '0;
   endtask

   task automatic wait_result(input int target);
      for (int i = 0; i < 300 && nres < target; i++) begin
         @(negedge clk);
         #1;
      end
      if (nres < target) begin
         checks++;
         errors++;
         $display("FAIL wait_result: got %0d results expected %0d", nres, target);
      end
   endtask

   // Beat driver: pop accepted beats (or one-cycle gaps), present the next head.
   initial begin : driver
      logic [N-1:0] fire;
      forever begin
         @(negedge clk);
         fire = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int r = 0; r < N; r++) begin
            if (bq[r].size() > 0 && (fire[r] || !bq[r][0].v)) void'(bq[r].pop_front());
            if (bq[r].size() > 0) begin
               req_valid[r]           = bq[r][0].v;
               req_last[r]            = bq[r][0].l;
               req_data[r*BW +: BW]   = bq[r][0].d;
            end else begin
               req_valid[r] = 1'b0;
               req_last[r]  = 1'b0;
            end
         end
      end
   end

   // Monitor: grant sanity, result latency, backpressure stability, scoreboard.
   initial begin : monitor
      logic          prev_rv, prev_rr;
      logic [W-1:0]  prev_data;
      logic [IDW-1:0] prev_id;
      logic [N-1:0]  f;
      int            e;
      prev_rv = 1'b0; prev_rr = 1'b0; prev_data = '0; prev_id = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            prev_rv = 1'b0;
            continue;
         end
         chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         f = req_valid & req_ready;
         for (int r = 0; r < N; r++) begin
            if (req_ready[r]) rdy_cnt[r]++;
            if (f[r]) fire_cnt[r]++;
            if (f[r] && req_last[r]) last_fire_cyc = cyc;
         end
         if (res_valid) begin
            if (prev_rv && !prev_rr) begin
               chk("hold_data", res_data, prev_data);
               chk("hold_id", res_id, prev_id);
            end else if (!prev_rv) begin
               chk("res_latency", cyc, last_fire_cyc + 1);
            end
            if (res_ready) begin
               if (exp_id_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result: got id %0d data %0h expected none", res_id, res_data);
               end else begin
                  e = exp_id_q.pop_front();
                  chk("res_id", res_id, e);
                  if (exp_q[e].size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL res_data: got %0h expected no burst from %0d", res_data, e);
                  end else begin
                     chk("res_data", res_data, exp_q[e].pop_front());
                  end
               end
               got_id_q.push_back(int'(res_id));
               got_data_q.push_back(res_data);
               nres++;
            end
         end
         prev_rv = res_valid; prev_rr = res_ready; prev_data = res_data; prev_id = res_id;
      end
   end

   initial begin : main
      int base;
      for (int r = 0; r < N; r++) begin fire_cnt[r] = 0; rdy_cnt[r] = 0; end
      rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      @(posedge clk); #2; rst_n = 1'b1;
      @(negedge clk); #1;

      // Single one-beat burst from requester 0.
      add_burst(0, '{32'h04030201, 32'h0, 32'h0, 32'h0}, 1, -1);
      exp_id_q.push_back(0);
      @(negedge clk); #1;
      chk("t1_ready_idle", req_ready, 4'b0000);
      @(negedge clk); #1;
      chk("t1_ready_grant", req_ready, 4'b0001);
      wait_result(1);
      chk("t1_data", got_data_q[0], 8'h0A);
      chk("t1_id", got_id_q[0], 0);

      // Three-beat burst from requester 2.
      for (int r = 0; r < N; r++) rdy_cnt[r] = 0;
      add_burst(2, '{32'h01010101, 32'h01010101, 32'h01010101, 32'h0}, 3, -1);
      exp_id_q.push_back(2);
      wait_result(2);
      chk("t2_data", got_data_q[1], 8'h0C);
      chk("t2_id", got_id_q[1], 2);
      chk("t2_rdy2_cycles", rdy_cnt[2], 3);
      chk("t2_rdy_others", rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3], 0);

      // Round robin from reset: 0, 1, 3 then 0 again.
      @(posedge clk); #2; rst_n = 1'b0;
      flush_all();
      add_burst(0, '{32'h01010101, 32'h0, 32'h0, 32'h0}, 1, -1);
      add_burst(0, '{32'h11111111, 32'h0, 32'h0, 32'h0}, 1, -1);
      add_burst(1, '{32'h02020202, 32'h0, 32'h0, 32'h0}, 1, -1);
      add_burst(3, '{32'h10203040, 32'h0, 32'h0, 32'h0}, 1, -1);
      exp_id_q = '{0, 1, 3, 0};
      repeat (2) @(posedge clk); #2; rst_n = 1'b1;
      base = nres;
      wait_result(base + 4);
      chk("t3_id0", got_id_q[base], 0);
      chk("t3_id1", got_id_q[base + 1], 1);
      chk("t3_id2", got_id_q[base + 2], 3);
      chk("t3_id3", got_id_q[base + 3], 0);
      chk("t3_data0", got_data_q[base], 8'h04);
      chk("t3_data2", got_data_q[base + 2], 8'hA0);
      chk("t3_data3", got_data_q[base + 3], 8'h44);

      // Overflow: two all-FF beats with a stall between them.
      base = nres;
      add_burst(1, '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0}, 2, 0);
      exp_id_q.push_back(1);
      wait_result(base + 1);
`ifdef TREE_ADDER_ARB_SAT_EN
      chk("t4_sat", got_data_q[base], 8'hFF);
`else
      chk("t4_wrap", got_data_q[base], 8'hF8);
`endif

      // Backpressure on the result port with a competing requester.
      @(posedge clk); #2; res_ready = 1'b0;
      add_burst(3, '{32'h04030201, 32'h0, 32'h0, 32'h0}, 1, -1);
      add_burst(0, '{32'h05050505, 32'h0, 32'h0, 32'h0}, 1, -1);
      exp_id_q.push_back(3);
      exp_id_q.push_back(0);
      for (int i = 0; i < 50 && !res_valid; i++) begin @(negedge clk); #1; end
      chk("t5_res_valid_seen", res_valid, 1);
      repeat (5) begin
         @(negedge clk); #1;
         chk("t5_hold_valid", res_valid, 1);
         chk("t5_no_ready", req_ready, 0);
         chk("t5_hold_id", res_id, 3);
         chk("t5_hold_data", res_data, 8'h0A);
      end
      base = nres;
      @(posedge clk); #2; res_ready = 1'b1;
      wait_result(base + 1);
      @(negedge clk); #1;
      chk("t5_one_result", nres, base + 1);
      chk("t5_valid_drop", res_valid, 0);
      wait_result(base + 2);
      chk("t5_next_id", got_id_q[base + 1], 0);
      chk("t5_next_data", got_data_q[base + 1], 8'h14);

      // Reset after the first of three beats discards the burst.
      base = fire_cnt[0];
      add_burst(0, '{32'h01010101, 32'h01010101, 32'h01010101, 32'h0}, 3, -1);
      exp_id_q.push_back(0);
      for (int i = 0; i < 50 && fire_cnt[0] == base; i++) begin @(negedge clk); #1; end
      chk("t6_beat1", fire_cnt[0], base + 1);
      @(posedge clk); #2; rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", req_ready, 0);
      chk("t6_rst_valid", res_valid, 0);
      chk("t6_rst_data", res_data, 0);
      chk("t6_rst_id", res_id, 0);
      flush_all();
      base = nres;
      repeat (2) @(posedge clk); #2; rst_n = 1'b1;
      add_burst(0, '{32'h04030201, 32'h0, 32'h0, 32'h0}, 1, -1);
      exp_id_q.push_back(0);
      wait_result(base + 1);
      chk("t6_data", got_data_q[base], 8'h0A);
      chk("t6_id", got_id_q[base], 0);
      repeat (5) @(negedge clk);
      #1;
      chk("t6_no_stale", nres, base + 1);
      chk("leftover_results", exp_id_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
